// File: rtl/vend_session_ctrl_if.sv
// vend_session_ctrl_if: panel and core signals shared by the session controller and its environment
interface vend_session_ctrl_if #(parameter int N_REQ = 4);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] coin;
  logic [N_REQ-1:0]   cancel;
  logic [N_REQ-1:0]   grant;
  logic [1:0]         core_coin;
  logic               core_rst;
  logic               core_vend;
  logic [1:0]         core_change;
  logic               rsp_valid;
  logic [IW-1:0]      rsp_id;
  logic               rsp_vend;
  logic [1:0]         rsp_change;
  logic               rsp_err;
  modport slave (
    input  req, coin, cancel, core_vend, core_change,
    output grant, core_coin, core_rst, rsp_valid, rsp_id, rsp_vend, rsp_change, rsp_err
  );
  modport master (
    output req, coin, cancel, core_vend, core_change,
    input  grant, core_coin, core_rst, rsp_valid, rsp_id, rsp_vend, rsp_change, rsp_err
  );
endinterface

// File: rtl/vend_session_ctrl.sv
// vend_session_ctrl: round-robin shares one vending core among N coin panels, buffering and replaying each session's coins
module vend_session_ctrl #(
  parameter int N_REQ        = 4,
  parameter int IDLE_TIMEOUT = 31,
  parameter int RSP_TIMEOUT  = 4
) (
  input logic clk,
  input logic rst,
  vend_session_ctrl_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam int WW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_PLAY, S_DRAIN, S_WAIT_RSP, S_REPORT} state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_owner, r_rr, w_pick, w_owner;
  logic [4:0]      r_credit, w_credit, w_add;
  logic [2:0][1:0] r_buf, w_buf;
  logic [1:0]      r_cnt, w_cnt, r_idx, w_idx, w_oc, w_core_coin;
  logic [TW-1:0]   r_idle, w_idle;
  logic [WW-1:0]   r_wait, w_wait;
  logic            r_cap, w_cap, r_vend, w_vend, r_err, w_err;
  logic [1:0]      r_change, w_change;
  logic            w_acc, w_hit, w_any, w_stop, w_rep;
  logic [N_REQ-1:0] r_grant;
  logic [1:0]      r_core_coin, r_rsp_change;
  logic            r_core_rst, r_rsp_valid, r_rsp_vend, r_rsp_err;
  logic [IW-1:0]   r_rsp_id;

  // First requester at or after rr_ptr; scanning downward lets the nearest one win
  always_comb begin
    int j;
    w_pick = r_rr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(r_rr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (bus.req[j]) w_pick = IW'(j);
    end
  end

  always_comb begin
    w_any    = |bus.req;
    w_oc     = bus.coin[2*r_owner +: 2];
    w_acc    = (r_state == S_COLLECT) && (w_oc == 2'b01 || w_oc == 2'b10);
    w_add    = (w_oc == 2'b10) ? 5'd10 : 5'd5;
    w_credit = w_acc ? r_credit + w_add : r_credit;
    w_cnt    = r_cnt + {1'b0, w_acc};
    w_idle   = w_acc ? '0 : r_idle + 1'b1;
    w_buf    = r_buf;
    if (w_acc) w_buf[r_cnt] = w_oc;
    w_stop   = bus.cancel[r_owner] | ~bus.req[r_owner] | (w_idle == TW'(IDLE_TIMEOUT));
    w_hit    = (r_state == S_PLAY || r_state == S_DRAIN || r_state == S_WAIT_RSP) && !r_cap &&
               (bus.core_vend || bus.core_change != 2'b00);
    w_cap    = r_cap | w_hit;
    w_vend   = w_hit ? bus.core_vend : r_vend;
    w_change = w_hit ? bus.core_change : r_change;
  end

  always_comb begin
    w_next = r_state;
    w_idx  = r_idx;
    w_wait = r_wait;
    w_err  = r_err;
    case (r_state)
      S_IDLE:    w_next = w_any ? S_COLLECT : S_IDLE;
      S_COLLECT: begin
        w_idx = '0;
        if (w_credit >= 5'd15) w_next = S_PLAY;
        else if (w_stop) w_next = (w_credit == 5'd0) ? S_REPORT : S_PLAY;
      end
      S_PLAY: begin
        w_next = (r_idx == r_cnt - 2'd1) ? S_DRAIN : S_PLAY;
        w_idx  = (r_idx == r_cnt - 2'd1) ? r_idx : r_idx + 2'd1;
      end
      S_DRAIN: begin
        w_next = w_cap ? S_REPORT : S_WAIT_RSP;
        w_wait = '0;
      end
      S_WAIT_RSP: begin
        if (w_hit) w_next = S_REPORT;
        else if (r_wait == WW'(RSP_TIMEOUT - 1)) begin
          w_next = S_REPORT;
          w_err  = 1'b1;
        end else w_wait = r_wait + 1'b1;
      end
      S_REPORT:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs are computed for the coming cycle so every port leaves a flop
  always_comb begin
    w_owner     = (r_state == S_IDLE) ? w_pick : r_owner;
    w_rep       = (w_next == S_REPORT);
    w_core_coin = (w_next == S_PLAY) ? w_buf[w_idx] : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_rr         <= '0;
      r_credit     <= '0;
      r_buf        <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_idle       <= '0;
      r_wait       <= '0;
      r_cap        <= 1'b0;
      r_vend       <= 1'b0;
      r_change     <= 2'b00;
      r_err        <= 1'b0;
      r_grant      <= '0;
      r_core_coin  <= 2'b00;
      r_core_rst   <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_vend   <= 1'b0;
      r_rsp_change <= 2'b00;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_owner      <= w_owner;
      r_rr         <= (r_state == S_REPORT) ? ((r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + 1'b1) : r_rr;
      r_credit     <= (r_state == S_IDLE) ? '0 : w_credit;
      r_buf        <= (r_state == S_IDLE) ? '0 : w_buf;
      r_cnt        <= (r_state == S_IDLE) ? '0 : w_cnt;
      r_idle       <= (r_state == S_IDLE) ? '0 : w_idle;
      r_idx        <= w_idx;
      r_wait       <= w_wait;
      r_cap        <= (r_state == S_IDLE) ? 1'b0 : w_cap;
      r_vend       <= (r_state == S_IDLE) ? 1'b0 : w_vend;
      r_change     <= (r_state == S_IDLE) ? 2'b00 : w_change;
      r_err        <= (r_state == S_IDLE) ? 1'b0 : w_err;
      r_grant      <= (w_next == S_IDLE) ? '0 : N_REQ'(1) << w_owner;
      r_core_coin  <= w_core_coin;
      r_core_rst   <= w_rep & w_err;
      r_rsp_valid  <= w_rep;
      r_rsp_id     <= w_rep ? r_owner : '0;
      r_rsp_vend   <= w_rep & w_vend;
      r_rsp_change <= w_rep ? w_change : 2'b00;
      r_rsp_err    <= w_rep & w_err;
    end
  end

  assign bus.grant      = r_grant;
  assign bus.core_coin  = r_core_coin;
  assign bus.core_rst   = r_core_rst;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_vend   = r_rsp_vend;
  assign bus.rsp_change = r_rsp_change;
  assign bus.rsp_err    = r_rsp_err;
endmodule

// File: tb/tb_vend_session_ctrl.sv
// tb_vend_session_ctrl: directed sessions against a behavioural vending core model
module tb_vend_session_ctrl;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst;
  logic silent = 1'b0;
  logic [4:0] m_credit, m_add, m_sum;
  int n_run = 0, n_fail = 0, n_play = 0;
  int cyc, p0;
  logic seen;

  always #5 clk = ~clk;

  vend_session_ctrl_if #(.N_REQ(N)) bus ();
  vend_session_ctrl #(.N_REQ(N), .IDLE_TIMEOUT(31), .RSP_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Core: 5/10 coins accumulate, >=15 vends with change, 00 with credit refunds
  assign m_add = (bus.core_coin == 2'b10) ? 5'd10 : 5'd5;
  assign m_sum = m_credit + m_add;
  always @(posedge clk or posedge rst) begin
    if (rst || bus.core_rst) begin
      m_credit <= '0;
      bus.core_vend <= 1'b0;
      bus.core_change <= 2'b00;
    end else begin
      bus.core_vend <= 1'b0;
      bus.core_change <= 2'b00;
      if (bus.core_coin == 2'b00) begin
        if (m_credit != 0) begin
          if (!silent) bus.core_change <= (m_credit == 5'd5) ? 2'b01 : 2'b10;
          m_credit <= '0;
        end
      end else if (bus.core_coin != 2'b11) begin
        if (m_sum >= 5'd15) begin
          if (!silent) begin
            bus.core_vend <= 1'b1;
            bus.core_change <= (m_sum == 5'd20) ? 2'b01 : 2'b00;
          end
          m_credit <= '0;
        end else m_credit <= m_sum;
      end
    end
  end

  always @(negedge clk) if (bus.core_coin != 2'b00) n_play++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_coin(input int p, input logic [1:0] c);
    bus.coin[2*p +: 2] = c;
  endtask

  task automatic wait_rsp(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.rsp_valid && c < 200);
    check("rsp_seen", {31'd0, bus.rsp_valid}, 1);
  endtask

  task automatic wait_grant();
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.grant == '0 && c < 8);
  endtask

  initial begin
    bus.req = '0;
    bus.coin = '0;
    bus.cancel = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_coin", 32'(bus.core_coin), 0);
    check("rst_valid", 32'(bus.rsp_valid), 0);
    check("rst_core_rst", 32'(bus.core_rst), 0);
    rst = 1'b0;
    @(negedge clk);
    // Panel 0: 10 + 10, core sees 10,10,00 and gives change 5
    bus.req = 4'b0001;
    @(negedge clk);
    check("t1_grant", 32'(bus.grant), 32'b0001);
    set_coin(0, 2'b10);
    repeat (2) @(negedge clk);
    set_coin(0, 2'b00);
    check("t1_coin0", 32'(bus.core_coin), 2);
    @(negedge clk);
    check("t1_coin1", 32'(bus.core_coin), 2);
    @(negedge clk);
    check("t1_drain", 32'(bus.core_coin), 0);
    @(negedge clk);
    check("t1_valid", 32'(bus.rsp_valid), 1);
    check("t1_id", 32'(bus.rsp_id), 0);
    check("t1_vend", 32'(bus.rsp_vend), 1);
    check("t1_change", 32'(bus.rsp_change), 1);
    check("t1_err", 32'(bus.rsp_err), 0);
    bus.req = '0;
    @(negedge clk);
    check("t1_grant_drop", 32'(bus.grant), 0);
    // Panel 2: 5,5,5 exact price
    bus.req = 4'b0100;
    @(negedge clk);
    check("t2_grant", 32'(bus.grant), 32'b0100);
    p0 = n_play;
    set_coin(2, 2'b01);
    repeat (3) @(negedge clk);
    set_coin(2, 2'b00);
    wait_rsp(cyc);
    check("t2_lat", cyc, 4);
    check("t2_id", 32'(bus.rsp_id), 2);
    check("t2_vend", 32'(bus.rsp_vend), 1);
    check("t2_change", 32'(bus.rsp_change), 0);
    check("t2_play", n_play - p0, 3);
    bus.req = '0;
    @(negedge clk);
    // Panel 1: 10 then cancel -> refund 10
    bus.req = 4'b0010;
    @(negedge clk);
    check("t3_grant", 32'(bus.grant), 32'b0010);
    p0 = n_play;
    set_coin(1, 2'b10);
    @(negedge clk);
    set_coin(1, 2'b00);
    bus.cancel = 4'b0010;
    @(negedge clk);
    bus.cancel = '0;
    wait_rsp(cyc);
    check("t3_lat", cyc, 3);
    check("t3_id", 32'(bus.rsp_id), 1);
    check("t3_vend", 32'(bus.rsp_vend), 0);
    check("t3_change", 32'(bus.rsp_change), 2);
    check("t3_play", n_play - p0, 1);
    bus.req = '0;
    @(negedge clk);
    // Panel 1: cancel with no credit -> null result, no PLAY
    bus.req = 4'b0010;
    @(negedge clk);
    check("t3b_grant", 32'(bus.grant), 32'b0010);
    p0 = n_play;
    bus.cancel = 4'b0010;
    @(negedge clk);
    bus.cancel = '0;
    check("t3b_valid", 32'(bus.rsp_valid), 1);
    check("t3b_result", {bus.rsp_id, bus.rsp_vend, bus.rsp_change, bus.rsp_err}, {2'd1, 1'b0, 2'b00, 1'b0});
    check("t3b_play", n_play - p0, 0);
    bus.req = '0;
    @(negedge clk);
    // Panel 3: coin 5 then 31 silent cycles -> auto-cancel
    bus.req = 4'b1000;
    @(negedge clk);
    check("t4_grant", 32'(bus.grant), 32'b1000);
    set_coin(3, 2'b01);
    @(negedge clk);
    set_coin(3, 2'b00);
    repeat (30) @(negedge clk);
    check("t4_pre", {bus.grant, 2'b00, bus.core_coin}, {4'b1000, 2'b00, 2'b00});
    @(negedge clk);
    check("t4_play", 32'(bus.core_coin), 1);
    wait_rsp(cyc);
    check("t4_lat", cyc, 3);
    check("t4_id", 32'(bus.rsp_id), 3);
    check("t4_change", 32'(bus.rsp_change), 1);
    check("t4_vend", 32'(bus.rsp_vend), 0);
    bus.req = '0;
    @(negedge clk);
    // Round robin with all panels requesting; panel 1 feeds coins during panel 0's session
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      wait_grant();
      check($sformatf("t5_grant%0d", s), 32'(bus.grant), 32'(1) << s);
      p0 = n_play;
      set_coin(s, 2'b10);
      if (s == 0) set_coin(1, 2'b01);
      repeat (2) @(negedge clk);
      bus.coin = '0;
      wait_rsp(cyc);
      check($sformatf("t5_id%0d", s), 32'(bus.rsp_id), s);
      check($sformatf("t5_change%0d", s), {bus.rsp_vend, bus.rsp_change}, {1'b1, 2'b01});
      check($sformatf("t5_play%0d", s), n_play - p0, 2);
    end
    bus.req = '0;
    @(negedge clk);
    // Silent core -> error after the response timeout with a core_rst pulse
    silent = 1'b1;
    bus.req = 4'b0100;
    wait_grant();
    check("t6_grant", 32'(bus.grant), 32'b0100);
    set_coin(2, 2'b10);
    repeat (2) @(negedge clk);
    set_coin(2, 2'b00);
    wait_rsp(cyc);
    check("t6_lat", cyc, 7);
    check("t6_err", 32'(bus.rsp_err), 1);
    check("t6_core_rst", 32'(bus.core_rst), 1);
    check("t6_result", {bus.rsp_vend, bus.rsp_change}, 0);
    @(negedge clk);
    check("t6_core_rst_pulse", 32'(bus.core_rst), 0);
    bus.req = '0;
    silent = 1'b0;
    @(negedge clk);
    // Reset during PLAY aborts immediately
    bus.req = 4'b0001;
    wait_grant();
    set_coin(0, 2'b10);
    repeat (2) @(negedge clk);
    bus.coin = '0;
    check("t7_in_play", 32'(bus.core_coin), 2);
    #1 rst = 1'b1;
    #1;
    check("t7_grant", 32'(bus.grant), 0);
    check("t7_coin", 32'(bus.core_coin), 0);
    check("t7_valid", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    bus.req = '0;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid;
    end
    check("t7_no_rsp", 32'(seen), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
